addsub_sched: RTL and testbench

ADDSUB_SCHED -- requirements
Module: addsub_sched

---
 rtl/addsub_sched_if.sv | 32 +++
 rtl/addsub_sched.sv | 176 +++++++++++++++++
 tb/tb_addsub_sched.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/addsub_sched_if.sv
// Requester and shared-unit signal bundle for addsub_sched.
// slave = scheduler side, master = requesters plus the shared add/sub unit.
interface addsub_sched_if;
  logic        req0, req1;
  logic [31:0] A0, B0, A1, B1;
  logic [3:0]  control0, control1;
  logic        busy0, busy1;
  logic        done0, done1;
  logic [31:0] C0, C1;
  logic        sign0, sign1;
  logic        err0, err1;
  logic [31:0] au_A, au_B;
  logic [3:0]  au_control;
  logic        au_start;
  logic        au_finish;
  logic [31:0] au_C;
  logic        au_sign;

  modport slave (
    input  req0, req1, A0, B0, A1, B1, control0, control1,
    input  au_finish, au_C, au_sign,
    output busy0, busy1, done0, done1, C0, C1, sign0, sign1, err0, err1,
    output au_A, au_B, au_control, au_start
  );

  modport master (
    output req0, req1, A0, B0, A1, B1, control0, control1,
    output au_finish, au_C, au_sign,
    input  busy0, busy1, done0, done1, C0, C1, sign0, sign1, err0, err1,
    input  au_A, au_B, au_control, au_start
  );
endinterface

// File: rtl/addsub_sched.sv
// Two-port round-robin scheduler sharing one add/sub unit (IDLE/ISSUE/WAIT/RESP).
// Optional WAIT timeout is compiled in with ADDSUB_SCHED_TIMEOUT_EN.
module addsub_sched #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input logic           clock,
  input logic           reset,
  addsub_sched_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e            state_q;
  logic [31:0]       a0_q, b0_q, a1_q, b1_q;
  logic [3:0]        ctl0_q, ctl1_q;
  logic [1:0]        pend_q, busy_q, done_q, sign_q, err_q;
  logic [1:0][31:0]  c_q;
  logic              sel_q, rr_q;
  logic [31:0]       au_a_q, au_b_q;
  logic [3:0]        au_ctl_q;
  logic              au_start_q;
  logic              sel_d, op_ok_d;

`ifdef ADDSUB_SCHED_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] wait_cnt_q;
`else
  // TIMEOUT_CYCLES only matters in the timeout build.
  if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
  end
`endif

  // Arbitration: pointer breaks ties, otherwise the single pending port wins.
  always_comb begin
    sel_d = 1'b0;
    if (pend_q == 2'b11) begin
      sel_d = rr_q;
    end else if (pend_q[1]) begin
      sel_d = 1'b1;
    end else begin
      sel_d = 1'b0;
    end
    op_ok_d = sel_d ? (ctl1_q[3:2] == 2'b10) : (ctl0_q[3:2] == 2'b10);
  end

  // Request capture, scheduler FSM and all registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      a0_q       <= 32'd0;
      b0_q       <= 32'd0;
      a1_q       <= 32'd0;
      b1_q       <= 32'd0;
      ctl0_q     <= 4'd0;
      ctl1_q     <= 4'd0;
      pend_q     <= 2'b00;
      busy_q     <= 2'b00;
      done_q     <= 2'b00;
      sign_q     <= 2'b00;
      err_q      <= 2'b00;
      c_q        <= '0;
      sel_q      <= 1'b0;
      rr_q       <= 1'b0;
      au_a_q     <= 32'd0;
      au_b_q     <= 32'd0;
      au_ctl_q   <= 4'd0;
      au_start_q <= 1'b0;
`ifdef ADDSUB_SCHED_TIMEOUT_EN
      wait_cnt_q <= '0;
`endif
    end else begin
      done_q     <= 2'b00;
      au_start_q <= 1'b0;

      if (bus.req0 && !busy_q[0]) begin
        a0_q      <= bus.A0;
        b0_q      <= bus.B0;
        ctl0_q    <= bus.control0;
        pend_q[0] <= 1'b1;
        busy_q[0] <= 1'b1;
      end
      if (bus.req1 && !busy_q[1]) begin
        a1_q      <= bus.A1;
        b1_q      <= bus.B1;
        ctl1_q    <= bus.control1;
        pend_q[1] <= 1'b1;
        busy_q[1] <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (pend_q != 2'b00) begin
            sel_q         <= sel_d;
            pend_q[sel_d] <= 1'b0;
            au_a_q        <= sel_d ? a1_q : a0_q;
            au_b_q        <= sel_d ? b1_q : b0_q;
            au_ctl_q      <= sel_d ? ctl1_q : ctl0_q;
            if (op_ok_d) begin
              state_q    <= ISSUE;
              au_start_q <= 1'b1;
            end else begin
              // Unsupported opcode: answer with an error, never touch the unit.
              state_q       <= RESP;
              done_q[sel_d] <= 1'b1;
              c_q[sel_d]    <= 32'd0;
              sign_q[sel_d] <= 1'b0;
              err_q[sel_d]  <= 1'b1;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        ISSUE: begin
          state_q <= WAIT;
`ifdef ADDSUB_SCHED_TIMEOUT_EN
          wait_cnt_q <= '0;
`endif
        end
        WAIT: begin
          if (bus.au_finish) begin
            state_q       <= RESP;
            done_q[sel_q] <= 1'b1;
            c_q[sel_q]    <= bus.au_C;
            sign_q[sel_q] <= bus.au_sign;
            err_q[sel_q]  <= 1'b0;
`ifdef ADDSUB_SCHED_TIMEOUT_EN
          end else if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state_q       <= RESP;
            done_q[sel_q] <= 1'b1;
            c_q[sel_q]    <= 32'd0;
            sign_q[sel_q] <= 1'b0;
            err_q[sel_q]  <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
`else
          end else begin
            state_q <= WAIT;
`endif
          end
        end
        RESP: begin
          state_q        <= IDLE;
          busy_q[sel_q]  <= 1'b0;
          // Priority passes to the other port only if it was left waiting.
          if (pend_q[~sel_q]) begin
            rr_q <= ~sel_q;
          end else begin
            rr_q <= rr_q;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy0      = busy_q[0];
  assign bus.busy1      = busy_q[1];
  assign bus.done0      = done_q[0];
  assign bus.done1      = done_q[1];
  assign bus.C0         = c_q[0];
  assign bus.C1         = c_q[1];
  assign bus.sign0      = sign_q[0];
  assign bus.sign1      = sign_q[1];
  assign bus.err0       = err_q[0];
  assign bus.err1       = err_q[1];
  assign bus.au_A       = au_a_q;
  assign bus.au_B       = au_b_q;
  assign bus.au_control = au_ctl_q;
  assign bus.au_start   = au_start_q;
endmodule

// File: tb/tb_addsub_sched.sv
// Scoreboard bench for addsub_sched: per-port expected-result queues, a
// behavioural shared unit, latency/order/reset checks.
module tb_addsub_sched;
  typedef struct {
    logic [31:0] c;
    logic        sign;
    logic        err;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  addsub_sched_if bus ();

  addsub_sched #(.TIMEOUT_CYCLES(64)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  exp_t sb0[$];
  exp_t sb1[$];
  int   order_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   done_cnt0 = 0;
  int   done_cnt1 = 0;
  int   start_cnt = 0;
  int   last_start_cyc = 0;
  int   last_done_cyc  = 0;
  int   req_cyc = 0;
  int   unit_lat = 1;
  bit   unit_hold = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] au_model(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] ctl);
    case (ctl[1:0])
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return b - a;
      default: return (32'd0 - a) - b;
    endcase
  endfunction

  function automatic exp_t expect_of(input logic [31:0] a, input logic [31:0] b,
                                     input logic [3:0] ctl);
    exp_t e;
    if (ctl[3:2] != 2'b10) begin
      e.c = 32'd0; e.sign = 1'b0; e.err = 1'b1;
    end else begin
      e.c = au_model(a, b, ctl); e.sign = e.c[31]; e.err = 1'b0;
    end
    return e;
  endfunction

  // Output monitor: pops the scoreboard on every done pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (bus.au_start) begin
        start_cnt++;
        last_start_cyc = cyc;
      end
      if (bus.done0 && bus.done1) check_val("dual_done", 32'd1, 32'd0);
      if (bus.done0) begin
        done_cnt0++; last_done_cyc = cyc; order_q.push_back(0);
        if (sb0.size() == 0) check_val("spurious_done0", 32'd1, 32'd0);
        else begin
          e = sb0.pop_front();
          check_val("C0", bus.C0, e.c);
          check_val("sign0", 32'(bus.sign0), 32'(e.sign));
          check_val("err0", 32'(bus.err0), 32'(e.err));
        end
      end
      if (bus.done1) begin
        done_cnt1++; last_done_cyc = cyc; order_q.push_back(1);
        if (sb1.size() == 0) check_val("spurious_done1", 32'd1, 32'd0);
        else begin
          e = sb1.pop_front();
          check_val("C1", bus.C1, e.c);
          check_val("sign1", 32'(bus.sign1), 32'(e.sign));
          check_val("err1", 32'(bus.err1), 32'(e.err));
        end
      end
    end
  end

  // Behavioural shared unit: answers unit_lat cycles after au_start.
  initial begin
    logic [31:0] a, b, r;
    logic [3:0]  ctl;
    bus.au_finish = 1'b0;
    bus.au_C      = 32'd0;
    bus.au_sign   = 1'b0;
    forever begin
      @(negedge clock);
      if (bus.au_start && !unit_hold) begin
        a = bus.au_A; b = bus.au_B; ctl = bus.au_control;
        r = au_model(a, b, ctl);
        repeat (unit_lat) @(posedge clock);
        #1;
        bus.au_finish = 1'b1;
        bus.au_C      = r;
        bus.au_sign   = r[31];
        @(posedge clock);
        #1;
        bus.au_finish = 1'b0;
        bus.au_C      = 32'hDEAD_BEEF;
        bus.au_sign   = 1'b1;
      end
    end
  end

  task automatic drive_port(input int p, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] ctl);
    if (p == 0) begin
      bus.req0 = 1'b1; bus.A0 = a; bus.B0 = b; bus.control0 = ctl;
    end else begin
      bus.req1 = 1'b1; bus.A1 = a; bus.B1 = b; bus.control1 = ctl;
    end
  endtask

  task automatic push_exp(input int p, input exp_t e);
    if (p == 0) sb0.push_back(e);
    else sb1.push_back(e);
  endtask

  task automatic end_req();
    @(posedge clock);
    #1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
  endtask

  task automatic issue(input int p, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] ctl, input bit accept);
    @(negedge clock);
    drive_port(p, a, b, ctl);
    req_cyc = cyc;
    if (accept) push_exp(p, expect_of(a, b, ctl));
    end_req();
  endtask

  task automatic issue_pair(input logic [31:0] a0, input logic [31:0] b0, input logic [3:0] c0,
                            input logic [31:0] a1, input logic [31:0] b1, input logic [3:0] c1);
    @(negedge clock);
    drive_port(0, a0, b0, c0);
    drive_port(1, a1, b1, c1);
    req_cyc = cyc;
    push_exp(0, expect_of(a0, b0, c0));
    push_exp(1, expect_of(a1, b1, c1));
    end_req();
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while ((sb0.size() + sb1.size()) != 0 && k < budget) begin
      @(posedge clock);
      k++;
    end
    check_val("drain", 32'(sb0.size() + sb1.size()), 32'd0);
    repeat (2) @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    sb0.delete();
    sb1.delete();
    order_q.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    check_val({tag, "_busy"}, 32'({bus.busy1, bus.busy0}), 32'd0);
    check_val({tag, "_done"}, 32'({bus.done1, bus.done0}), 32'd0);
    check_val({tag, "_err"}, 32'({bus.err1, bus.err0}), 32'd0);
    check_val({tag, "_sign"}, 32'({bus.sign1, bus.sign0}), 32'd0);
    check_val({tag, "_C0"}, bus.C0, 32'd0);
    check_val({tag, "_C1"}, bus.C1, 32'd0);
    check_val({tag, "_au_A"}, bus.au_A, 32'd0);
    check_val({tag, "_au_B"}, bus.au_B, 32'd0);
    check_val({tag, "_au_ctl_start"}, 32'({bus.au_control, bus.au_start}), 32'd0);
  endtask

  initial begin
    int n;
    int d0;
    int s;
    int want[4];
    logic [31:0] ra, rb, rc, rd;
    logic [3:0]  k0, k1;
    reset = 1'b1;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.A0 = 32'd0; bus.B0 = 32'd0; bus.A1 = 32'd0; bus.B1 = 32'd0;
    bus.control0 = 4'd0; bus.control1 = 4'd0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_outputs_zero("reset");
    reset = 1'b0;

    // Minimum latency: ADDPN 5-3.
    issue(0, 32'd5, 32'd3, 4'b1001, 1'b1);
    n = req_cyc;
    wait_drain(40);
    check_val("lat_start", 32'(last_start_cyc - n), 32'd2);
    check_val("lat_done", 32'(last_done_cyc - n), 32'd4);
    check_val("C0_value", bus.C0, 32'd2);

    // Simultaneous requests after reset: port 0 then port 1.
    do_reset();
    d0 = done_cnt0; s = done_cnt1;
    issue_pair(32'd100, 32'd1, 4'b1000, 32'd7, 32'd9, 4'b1010);
    wait_drain(60);
    check_val("pair_cnt", 32'(order_q.size()), 32'd2);
    check_val("pair_first", 32'((order_q.size() > 0) ? order_q[0] : -1), 32'd0);
    check_val("pair_done0", 32'(done_cnt0 - d0), 32'd1);
    check_val("pair_done1", 32'(done_cnt1 - s), 32'd1);

    // Two back-to-back pairs: order 0,1,1,0.
    do_reset();
    issue_pair(32'd1, 32'd2, 4'b1000, 32'd3, 32'd4, 4'b1011);
    wait_drain(60);
    issue_pair(32'd50, 32'd60, 4'b1001, 32'd70, 32'd80, 4'b1010);
    wait_drain(60);
    want = '{0, 1, 1, 0};
    check_val("order_cnt", 32'(order_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check_val($sformatf("order%0d", i), 32'((i < order_q.size()) ? order_q[i] : -1),
                32'(want[i]));
    end

    // Request while busy is ignored.
    d0 = done_cnt0;
    issue(0, 32'd10, 32'd4, 4'b1000, 1'b1);
    issue(0, 32'd99, 32'd1, 4'b1011, 1'b0);
    wait_drain(40);
    check_val("busy_ignore_done", 32'(done_cnt0 - d0), 32'd1);
    check_val("busy_ignore_C0", bus.C0, 32'd14);

    // Unsupported opcode: error response with no unit start.
    s = start_cnt;
    issue(1, 32'd7, 32'd7, 4'b0110, 1'b1);
    n = req_cyc;
    wait_drain(40);
    check_val("bad_op_lat", 32'(last_done_cyc - n), 32'd2);
    check_val("bad_op_nostart", 32'(start_cnt - s), 32'd0);
    check_val("bad_op_err1", 32'(bus.err1), 32'd1);

    // Mixed traffic with varying unit latency.
    for (int i = 0; i < 6; i++) begin
      unit_lat = $urandom_range(1, 3);
      ra = $urandom; rb = $urandom; rc = $urandom; rd = $urandom;
      k0 = {2'b10, 2'($urandom_range(0, 3))};
      k1 = (i == 3) ? 4'b0001 : {2'b10, 2'($urandom_range(0, 3))};
      issue_pair(ra, rb, k0, rc, rd, k1);
      wait_drain(80);
    end
    unit_lat = 1;

    // Reset during WAIT abandons the operation.
    unit_hold = 1'b1;
    issue(0, 32'd11, 32'd22, 4'b1000, 1'b0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check_outputs_zero("mid_reset");
    d0 = done_cnt0;
    repeat (8) @(negedge clock);
    check_val("mid_reset_no_done", 32'(done_cnt0 - d0), 32'd0);

`ifdef ADDSUB_SCHED_TIMEOUT_EN
    // Unit never answers: timeout error after 64 WAIT cycles.
    begin
      exp_t e;
      e.c = 32'd0; e.sign = 1'b0; e.err = 1'b1;
      issue(0, 32'd1, 32'd2, 4'b1000, 1'b0);
      n = req_cyc;
      sb0.push_back(e);
      wait_drain(200);
      check_val("timeout_lat", 32'(last_done_cyc - n), 32'd67);
    end
`endif
    unit_hold = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
